// File: rtl/stream_width_converter.sv
// ============================================================================
// Module   : stream_width_converter
// Brief    : Integer-ratio valid/ready stream gearbox (upsize, downsize or pass)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_width_converter #(
    parameter int IN_W      = 2,
    parameter int OUT_W     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic             out_partial,
    input  logic             out_ready
);

    localparam int c_ratio = (OUT_W > IN_W) ? OUT_W / IN_W : IN_W / OUT_W;
    localparam int c_cw    = (c_ratio > 1) ? $clog2(c_ratio) : 1;
    localparam logic [c_cw-1:0] c_cnt_max = c_cw'(c_ratio - 1);

    if (((OUT_W > IN_W) ? (OUT_W % IN_W) : (IN_W % OUT_W)) != 0) begin : g_bad_ratio
        $error("stream_width_converter: IN_W and OUT_W must be integer multiples");
    end

    if (OUT_W > IN_W) begin : g_upsize
        logic [c_cw-1:0]  r_cnt;
        logic [OUT_W-1:0] r_acc;
        logic [OUT_W-1:0] r_data;
        logic             r_valid;
        logic             r_last;
        logic             r_partial;
        logic [OUT_W-1:0] w_word;
        logic             w_accept;
        logic             w_done;

        assign in_ready = !r_valid || out_ready;
        assign w_accept = in_valid && in_ready;
        assign w_done   = w_accept && (in_last || (r_cnt == c_cnt_max));

        // Accumulator with the current chunk merged into its slot; unwritten slots stay zero.
        always_comb begin
            w_word = r_acc;
            for (int k = 0; k < c_ratio; k++) begin
                if ((LSB_FIRST ? k : (c_ratio - 1 - k)) == int'(r_cnt)) begin
                    w_word[k*IN_W +: IN_W] = in_data;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt     <= '0;
                r_acc     <= '0;
                r_data    <= '0;
                r_valid   <= 1'b0;
                r_last    <= 1'b0;
                r_partial <= 1'b0;
            end else if (w_done) begin
                r_data    <= w_word;
                r_valid   <= 1'b1;
                r_last    <= in_last;
                r_partial <= in_last && (r_cnt != c_cnt_max);
                r_cnt     <= '0;
                r_acc     <= '0;
            end else begin
                if (w_accept) begin
                    r_acc <= w_word;
                    r_cnt <= r_cnt + c_cw'(1);
                end
                if (out_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end

        assign out_data    = r_data;
        assign out_valid   = r_valid;
        assign out_last    = r_last;
        assign out_partial = r_partial;
    end else if (IN_W > OUT_W) begin : g_downsize
        logic [IN_W-1:0] r_shift;
        logic [c_cw-1:0] r_cnt;
        logic            r_valid;
        logic            r_last;
        logic            w_cnt_end;
        logic            w_accept;

        assign w_cnt_end = (r_cnt == c_cnt_max);
        assign in_ready  = !r_valid || (out_ready && w_cnt_end);
        assign w_accept  = in_valid && in_ready;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_shift <= '0;
                r_cnt   <= '0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else if (w_accept) begin
                r_shift <= in_data;
                r_cnt   <= '0;
                r_valid <= 1'b1;
                r_last  <= in_last;
            end else if (r_valid && out_ready) begin
                if (w_cnt_end) begin
                    r_valid <= 1'b0;
                    r_cnt   <= '0;
                    r_last  <= 1'b0;
                end else begin
                    r_shift <= LSB_FIRST ? (r_shift >> OUT_W) : (r_shift << OUT_W);
                    r_cnt   <= r_cnt + c_cw'(1);
                end
            end
        end

        assign out_data    = LSB_FIRST ? r_shift[OUT_W-1:0] : r_shift[IN_W-1 -: OUT_W];
        assign out_valid   = r_valid;
        assign out_last    = r_last && w_cnt_end;
        assign out_partial = 1'b0;
    end else begin : g_equal
        logic [OUT_W-1:0] r_data;
        logic             r_valid;
        logic             r_last;

        assign in_ready = !r_valid || out_ready;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_data  <= '0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else if (in_valid && in_ready) begin
                r_data  <= in_data;
                r_valid <= 1'b1;
                r_last  <= in_last;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end

        assign out_data    = r_data;
        assign out_valid   = r_valid;
        assign out_last    = r_last;
        assign out_partial = 1'b0;
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_width_converter.sv
// ============================================================================
// Module   : tb_stream_width_converter
// Brief    : Self-checking bench for stream_width_converter in four configurations
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_width_converter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // id 0: 2->8 LSB first, id 1: 8->2 LSB first, id 2: 8->32 MSB first, id 3: 4->4
    logic [1:0]  up_in_data;  logic up_in_valid, up_in_last, up_in_ready;
    logic [7:0]  up_out_data; logic up_out_valid, up_out_last, up_out_partial, up_out_ready;
    logic [7:0]  dn_in_data;  logic dn_in_valid, dn_in_last, dn_in_ready;
    logic [1:0]  dn_out_data; logic dn_out_valid, dn_out_last, dn_out_partial, dn_out_ready;
    logic [7:0]  be_in_data;  logic be_in_valid, be_in_last, be_in_ready;
    logic [31:0] be_out_data; logic be_out_valid, be_out_last, be_out_partial, be_out_ready;
    logic [3:0]  eq_in_data;  logic eq_in_valid, eq_in_last, eq_in_ready;
    logic [3:0]  eq_out_data; logic eq_out_valid, eq_out_last, eq_out_partial, eq_out_ready;

    stream_width_converter #(.IN_W(2), .OUT_W(8), .LSB_FIRST(1'b1)) u_up (
        .clk(clk), .reset(reset), .in_data(up_in_data), .in_valid(up_in_valid),
        .in_last(up_in_last), .in_ready(up_in_ready), .out_data(up_out_data),
        .out_valid(up_out_valid), .out_last(up_out_last), .out_partial(up_out_partial),
        .out_ready(up_out_ready));
    stream_width_converter #(.IN_W(8), .OUT_W(2), .LSB_FIRST(1'b1)) u_dn (
        .clk(clk), .reset(reset), .in_data(dn_in_data), .in_valid(dn_in_valid),
        .in_last(dn_in_last), .in_ready(dn_in_ready), .out_data(dn_out_data),
        .out_valid(dn_out_valid), .out_last(dn_out_last), .out_partial(dn_out_partial),
        .out_ready(dn_out_ready));
    stream_width_converter #(.IN_W(8), .OUT_W(32), .LSB_FIRST(1'b0)) u_be (
        .clk(clk), .reset(reset), .in_data(be_in_data), .in_valid(be_in_valid),
        .in_last(be_in_last), .in_ready(be_in_ready), .out_data(be_out_data),
        .out_valid(be_out_valid), .out_last(be_out_last), .out_partial(be_out_partial),
        .out_ready(be_out_ready));
    stream_width_converter #(.IN_W(4), .OUT_W(4), .LSB_FIRST(1'b1)) u_eq (
        .clk(clk), .reset(reset), .in_data(eq_in_data), .in_valid(eq_in_valid),
        .in_last(eq_in_last), .in_ready(eq_in_ready), .out_data(eq_out_data),
        .out_valid(eq_out_valid), .out_last(eq_out_last), .out_partial(eq_out_partial),
        .out_ready(eq_out_ready));

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        part;
    } beat_t;

    beat_t      q_up[$], q_dn[$], q_be[$], q_eq[$];
    logic [7:0] ch_up[$], ch_be[$];
    int n_checks = 0, n_fail = 0, n_extra = 0, n_tmo = 0, up_outs = 0;
    bit rand_done = 1'b0;
    logic [1:0] dn_exp [8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_beat(input string tag, input beat_t e, input logic [31:0] d,
                            input logic l, input logic p);
        check_eq({tag, "_data"}, d, e.data);
        check_eq({tag, "_last"}, 32'(l), 32'(e.last));
        check_eq({tag, "_partial"}, 32'(p), 32'(e.part));
    endtask

    // Reference model: frame chunks are packed into words with plain arithmetic.
    always @(negedge clk) begin
        if (reset) begin
            ch_up.delete(); ch_be.delete();
            q_up.delete(); q_dn.delete(); q_be.delete(); q_eq.delete();
        end else begin
            if (up_out_valid && up_out_ready) begin
                up_outs++;
                if (q_up.size() == 0) n_extra++;
                else cmp_beat("up", q_up.pop_front(), 32'(up_out_data), up_out_last, up_out_partial);
            end
            if (up_in_valid && up_in_ready) begin
                beat_t b;
                ch_up.push_back(8'(up_in_data));
                if (up_in_last || ch_up.size() == 4) begin
                    b = '0;
                    for (int k = 0; k < ch_up.size(); k++) b.data |= 32'(ch_up[k]) << (2 * k);
                    b.last = up_in_last;
                    b.part = up_in_last && (ch_up.size() < 4);
                    q_up.push_back(b);
                    ch_up.delete();
                end
            end
            if (dn_out_valid && dn_out_ready) begin
                if (q_dn.size() == 0) n_extra++;
                else cmp_beat("dn", q_dn.pop_front(), 32'(dn_out_data), dn_out_last, dn_out_partial);
            end
            if (dn_in_valid && dn_in_ready) begin
                for (int j = 0; j < 4; j++) begin
                    beat_t b;
                    b.data = 32'((dn_in_data >> (2 * j)) & 8'h03);
                    b.last = dn_in_last && (j == 3);
                    b.part = 1'b0;
                    q_dn.push_back(b);
                end
            end
            if (be_out_valid && be_out_ready) begin
                if (q_be.size() == 0) n_extra++;
                else cmp_beat("be", q_be.pop_front(), be_out_data, be_out_last, be_out_partial);
            end
            if (be_in_valid && be_in_ready) begin
                beat_t b;
                ch_be.push_back(be_in_data);
                if (be_in_last || ch_be.size() == 4) begin
                    b = '0;
                    for (int k = 0; k < ch_be.size(); k++) b.data |= 32'(ch_be[k]) << (8 * (3 - k));
                    b.last = be_in_last;
                    b.part = be_in_last && (ch_be.size() < 4);
                    q_be.push_back(b);
                    ch_be.delete();
                end
            end
            if (eq_out_valid && eq_out_ready) begin
                if (q_eq.size() == 0) n_extra++;
                else cmp_beat("eq", q_eq.pop_front(), 32'(eq_out_data), eq_out_last, eq_out_partial);
            end
            if (eq_in_valid && eq_in_ready) begin
                beat_t b;
                b.data = 32'(eq_in_data);
                b.last = eq_in_last;
                b.part = 1'b0;
                q_eq.push_back(b);
            end
        end
    end

    task automatic set_in(input int id, input logic [7:0] d, input logic l, input logic v);
        case (id)
            0: begin up_in_data = d[1:0]; up_in_last = l; up_in_valid = v; end
            1: begin dn_in_data = d;      dn_in_last = l; dn_in_valid = v; end
            2: begin be_in_data = d;      be_in_last = l; be_in_valid = v; end
            default: begin eq_in_data = d[3:0]; eq_in_last = l; eq_in_valid = v; end
        endcase
    endtask

    function automatic logic rdy(input int id);
        case (id)
            0: return up_in_ready;
            1: return dn_in_ready;
            2: return be_in_ready;
            default: return eq_in_ready;
        endcase
    endfunction

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // Offers one beat; returns 1 time unit after the edge that accepted it.
    task automatic send(input int id, input logic [7:0] d, input logic l);
        set_in(id, d, l, 1'b1);
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (rdy(id)) begin
                to_drive();
                set_in(id, 8'h00, 1'b0, 1'b0);
                return;
            end
        end
        n_tmo++;
        set_in(id, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic rnd_frames(input int id, input int nframes, input int maxlen);
        for (int f = 0; f < nframes; f++) begin
            int len;
            len = $urandom_range(1, maxlen);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) to_drive();
                send(id, 8'($urandom), i == len - 1);
            end
        end
    endtask

    initial begin
        int prev;
        reset = 1'b1;
        for (int id = 0; id < 4; id++) set_in(id, 8'h00, 1'b0, 1'b0);
        up_out_ready = 1'b1; dn_out_ready = 1'b1; be_out_ready = 1'b1; eq_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check_eq("rst_up_valid", 32'(up_out_valid), 0);
        check_eq("rst_up_data", 32'(up_out_data), 0);
        check_eq("rst_up_last", 32'(up_out_last), 0);
        check_eq("rst_up_partial", 32'(up_out_partial), 0);
        check_eq("rst_up_in_ready", 32'(up_in_ready), 1);
        check_eq("rst_dn_valid", 32'(dn_out_valid), 0);
        check_eq("rst_be_data", be_out_data, 0);
        to_drive();

        // Full 4-dibit frame, one output cycle exactly one cycle after the 4th beat
        send(0, 8'd1, 1'b0); send(0, 8'd2, 1'b0); send(0, 8'd3, 1'b0);
        check_eq("up_early_valid", 32'(up_out_valid), 0);
        send(0, 8'd0, 1'b1);
        @(negedge clk);
        check_eq("up_full_valid", 32'(up_out_valid), 1);
        check_eq("up_full_data", 32'(up_out_data), 32'h39);
        check_eq("up_full_last", 32'(up_out_last), 1);
        check_eq("up_full_partial", 32'(up_out_partial), 0);
        @(negedge clk);
        check_eq("up_full_once", 32'(up_out_valid), 0);

        // Early last flushes a partial word
        to_drive();
        send(0, 8'd3, 1'b0); send(0, 8'd2, 1'b1);
        @(negedge clk);
        check_eq("up_part_data", 32'(up_out_data), 32'h0B);
        check_eq("up_part_last", 32'(up_out_last), 1);
        check_eq("up_part_partial", 32'(up_out_partial), 1);

        // Backpressure: pending word blocks input and holds its data
        to_drive();
        up_out_ready = 1'b0;
        send(0, 8'd1, 1'b0); send(0, 8'd2, 1'b0); send(0, 8'd3, 1'b0); send(0, 8'd0, 1'b0);
        set_in(0, 8'd1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_in_ready", 32'(up_in_ready), 0);
            check_eq("bp_valid", 32'(up_out_valid), 1);
            check_eq("bp_data", 32'(up_out_data), 32'h39);
        end
        to_drive();
        up_out_ready = 1'b1;
        send(0, 8'd2, 1'b0); send(0, 8'd1, 1'b0); send(0, 8'd0, 1'b0); send(0, 8'd3, 1'b1);
        @(negedge clk);
        check_eq("bp_next_data", 32'(up_out_data), 32'hC6);
        check_eq("bp_next_last", 32'(up_out_last), 1);

        // Reset mid-word discards the accumulated dibits
        to_drive();
        send(0, 8'd3, 1'b0); send(0, 8'd3, 1'b0);
        reset = 1'b1;
        to_drive();
        reset = 1'b0;
        @(negedge clk);
        check_eq("rstmid_valid", 32'(up_out_valid), 0);
        check_eq("rstmid_data", 32'(up_out_data), 0);
        to_drive();
        prev = up_outs;
        send(0, 8'd1, 1'b0); send(0, 8'd2, 1'b0); send(0, 8'd3, 1'b0); send(0, 8'd0, 1'b1);
        @(negedge clk);
        check_eq("rstmid_word", 32'(up_out_data), 32'h39);
        repeat (3) @(negedge clk);
        check_eq("rstmid_count", 32'(up_outs - prev), 1);

        // Downsize back-to-back words: 8 consecutive output cycles
        to_drive();
        fork
            begin
                send(1, 8'hA5, 1'b0);
                send(1, 8'h3C, 1'b1);
            end
            begin
                for (int t = 0; t < 20 && !dn_out_valid; t++) @(negedge clk);
                if (!dn_out_valid) n_tmo++;
                for (int i = 0; i < 8; i++) begin
                    check_eq("dn_seq_valid", 32'(dn_out_valid), 1);
                    check_eq("dn_seq_data", 32'(dn_out_data), 32'(dn_exp[i]));
                    check_eq("dn_seq_last", 32'(dn_out_last), 32'(i == 7));
                    check_eq("dn_seq_in_ready", 32'(dn_in_ready), 32'(i % 4 == 3));
                    @(negedge clk);
                end
                check_eq("dn_seq_end", 32'(dn_out_valid), 0);
            end
        join

        // MSB-first byte to word
        to_drive();
        send(2, 8'h11, 1'b0); send(2, 8'h22, 1'b0); send(2, 8'h33, 1'b0); send(2, 8'h44, 1'b1);
        @(negedge clk);
        check_eq("be_valid", 32'(be_out_valid), 1);
        check_eq("be_data", be_out_data, 32'h11223344);
        check_eq("be_last", 32'(be_out_last), 1);
        check_eq("be_partial", 32'(be_out_partial), 0);

        // Randomized traffic with random backpressure on all four configurations
        to_drive();
        fork
            begin
                while (!rand_done) begin
                    to_drive();
                    if (!rand_done) begin
                        up_out_ready = ($urandom_range(0, 3) != 0);
                        dn_out_ready = ($urandom_range(0, 3) != 0);
                        be_out_ready = ($urandom_range(0, 3) != 0);
                        eq_out_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            end
        join_none
        fork
            rnd_frames(0, 40, 9);
            rnd_frames(1, 25, 3);
            rnd_frames(2, 25, 6);
            rnd_frames(3, 40, 3);
        join
        rand_done = 1'b1;
        @(posedge clk);
        #2;
        up_out_ready = 1'b1; dn_out_ready = 1'b1; be_out_ready = 1'b1; eq_out_ready = 1'b1;
        repeat (30) @(posedge clk);

        @(negedge clk);
        check_eq("drain_up", 32'(q_up.size()), 0);
        check_eq("drain_dn", 32'(q_dn.size()), 0);
        check_eq("drain_be", 32'(q_be.size()), 0);
        check_eq("drain_eq", 32'(q_eq.size()), 0);
        check_eq("pending_up", 32'(ch_up.size()), 0);
        check_eq("pending_be", 32'(ch_be.size()), 0);
        check_eq("extra_outputs", 32'(n_extra), 0);
        check_eq("timeouts", 32'(n_tmo), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
